// File: rtl/alu_lane_sequencer_pkg.sv
// Shared widths, sequencer state and small helpers for the ALU lane sequencer.
// Scalar field widths mirror the execute request carried by the ALU dispatch port.
package alu_lane_sequencer_pkg;

  localparam int unsigned NUM_THREADS   = 8;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NT_WIDTH      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned UUID_WIDTH    = 44;
  localparam int unsigned WID_WIDTH     = 4;
  localparam int unsigned PC_WIDTH      = 32;
  localparam int unsigned OP_TYPE_WIDTH = 4;
  localparam int unsigned OP_ARGS_WIDTH = 16;
  localparam int unsigned RD_WIDTH      = 5;

  typedef enum logic [0:0] {
    SeqIdle = 1'b0,
    SeqBusy = 1'b1
  } seq_state_e;

  function automatic int unsigned num_batches(int unsigned lanes);
    return NUM_THREADS / lanes;
  endfunction

  function automatic int unsigned pid_bits(int unsigned lanes);
    return (num_batches(lanes) > 1) ? $clog2(num_batches(lanes)) : 0;
  endfunction

  // Zero-bit pid still needs a one-bit port.
  function automatic int unsigned pid_width(int unsigned lanes);
    return (pid_bits(lanes) > 0) ? pid_bits(lanes) : 1;
  endfunction

  function automatic int unsigned lane_bits(int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(logic [NUM_THREADS-1:0] v);
    int unsigned        idx;
    logic [NUM_THREADS-1:0] t;
    idx = 0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      t = v >> (NUM_THREADS - 1 - i);
      if (t[0]) idx = NUM_THREADS - 1 - i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_lane_slice.sv
// Extracts lane batch cur_i (tmask and operand data) from the full-warp holding register.
module alu_lane_slice
  import alu_lane_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LANES = 1,
  parameter int unsigned PID_WIDTH = 1
) (
  input  logic [PID_WIDTH-1:0]        cur_i,
  input  logic [NUM_THREADS-1:0]      tmask_i,
  input  logic [NUM_THREADS*XLEN-1:0] rs1_i,
  input  logic [NUM_THREADS*XLEN-1:0] rs2_i,
  input  logic [NUM_THREADS*XLEN-1:0] rs3_i,
  output logic [NUM_LANES-1:0]        tmask_o,
  output logic [NUM_LANES*XLEN-1:0]   rs1_o,
  output logic [NUM_LANES*XLEN-1:0]   rs2_o,
  output logic [NUM_LANES*XLEN-1:0]   rs3_o
);

  assign tmask_o = NUM_LANES'(tmask_i >> (cur_i * NUM_LANES));
  assign rs1_o   = (NUM_LANES * XLEN)'(rs1_i >> (cur_i * NUM_LANES * XLEN));
  assign rs2_o   = (NUM_LANES * XLEN)'(rs2_i >> (cur_i * NUM_LANES * XLEN));
  assign rs3_o   = (NUM_LANES * XLEN)'(rs3_i >> (cur_i * NUM_LANES * XLEN));

endmodule

// File: rtl/alu_lane_sequencer.sv
// Splits one full-warp ALU request into NUM_LANES-wide batches, skipping empty batches,
// and tags each with pid/sop/eop and a batch-local leader tid.
module alu_lane_sequencer
  import alu_lane_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LANES = 1,
  parameter int unsigned BLOCK_IDX = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [UUID_WIDTH-1:0]           in_uuid,
  input  logic [WID_WIDTH-1:0]            in_wid,
  input  logic [NUM_THREADS-1:0]          in_tmask,
  input  logic [PC_WIDTH-1:0]             in_pc,
  input  logic [OP_TYPE_WIDTH-1:0]        in_op_type,
  input  logic [OP_ARGS_WIDTH-1:0]        in_op_args,
  input  logic [RD_WIDTH-1:0]             in_rd,
  input  logic                            in_wb,
  input  logic [NUM_THREADS*XLEN-1:0]     in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]     in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0]     in_rs3_data,
  input  logic [NT_WIDTH-1:0]             in_tid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [UUID_WIDTH-1:0]           out_uuid,
  output logic [WID_WIDTH-1:0]            out_wid,
  output logic [NUM_LANES-1:0]            out_tmask,
  output logic [PC_WIDTH-1:0]             out_pc,
  output logic [OP_TYPE_WIDTH-1:0]        out_op_type,
  output logic [OP_ARGS_WIDTH-1:0]        out_op_args,
  output logic [RD_WIDTH-1:0]             out_rd,
  output logic                            out_wb,
  output logic [NUM_LANES*XLEN-1:0]       out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]       out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]       out_rs3_data,
  output logic [pid_width(NUM_LANES)-1:0] out_pid,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [NT_WIDTH-1:0]             out_tid
);

  localparam int unsigned NB        = num_batches(NUM_LANES);
  localparam int unsigned PID_WIDTH = pid_width(NUM_LANES);
  localparam int unsigned LANE_BITS = lane_bits(NUM_LANES);

  seq_state_e state_q, state_d;
  logic [NB-1:0] rem_q, rem_d, rem_init;
  logic          sop_q, sop_d;

  logic [UUID_WIDTH-1:0]       uuid_q;
  logic [WID_WIDTH-1:0]        wid_q;
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [PC_WIDTH-1:0]         pc_q;
  logic [OP_TYPE_WIDTH-1:0]    op_type_q;
  logic [OP_ARGS_WIDTH-1:0]    op_args_q;
  logic [RD_WIDTH-1:0]         rd_q;
  logic                        wb_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [NT_WIDTH-1:0]         tid_q;

  logic [PID_WIDTH-1:0] cur;
  logic [LANE_BITS-1:0] lane_idx;
  logic                 last_batch;
  logic                 in_fire;
  logic                 out_fire;

  // Block index is a trace tag only; tid_q/lane_idx are each dead in one of the tid modes.
  logic unused_trace;
  assign unused_trace = ^{BLOCK_IDX, tid_q, lane_idx};

  // Remaining-batch mask for an incoming warp; an empty warp still emits batch 0.
  always_comb begin
    rem_init = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (|NUM_LANES'(in_tmask >> (b * NUM_LANES))) rem_init = rem_init | (NB'(1) << b);
    end
    if (in_tmask == '0) rem_init = NB'(1);
  end

  assign cur        = PID_WIDTH'(lowest_set(NUM_THREADS'(rem_q)));
  assign last_batch = $onehot(rem_q);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sop_d     = sop_q;
    out_valid = (state_q == SeqBusy);
    out_fire  = out_valid & out_ready;
    in_ready  = (state_q == SeqIdle) | (out_fire & last_batch);
    in_fire   = in_valid & in_ready;

    unique case (state_q)
      SeqIdle: if (in_fire) state_d = SeqBusy;
      SeqBusy: if (out_fire && last_batch && !in_fire) state_d = SeqIdle;
      default: state_d = SeqIdle;
    endcase

    if (out_fire) begin
      rem_d = rem_q & ~(NB'(1) << cur);
      sop_d = 1'b0;
    end
    // A new warp taken on the eop beat overrides the retiring warp's update.
    if (in_fire) begin
      rem_d = rem_init;
      sop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SeqIdle;
      rem_q   <= '0;
      sop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sop_q   <= sop_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uuid_q    <= '0;
      wid_q     <= '0;
      tmask_q   <= '0;
      pc_q      <= '0;
      op_type_q <= '0;
      op_args_q <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      tid_q     <= '0;
    end else if (in_fire) begin
      uuid_q    <= in_uuid;
      wid_q     <= in_wid;
      tmask_q   <= in_tmask;
      pc_q      <= in_pc;
      op_type_q <= in_op_type;
      op_args_q <= in_op_args;
      rd_q      <= in_rd;
      wb_q      <= in_wb;
      rs1_q     <= in_rs1_data;
      rs2_q     <= in_rs2_data;
      rs3_q     <= in_rs3_data;
      tid_q     <= in_tid;
    end
  end

  alu_lane_slice #(
    .NUM_LANES(NUM_LANES),
    .PID_WIDTH(PID_WIDTH)
  ) u_slice (
    .cur_i   (cur),
    .tmask_i (tmask_q),
    .rs1_i   (rs1_q),
    .rs2_i   (rs2_q),
    .rs3_i   (rs3_q),
    .tmask_o (out_tmask),
    .rs1_o   (out_rs1_data),
    .rs2_o   (out_rs2_data),
    .rs3_o   (out_rs3_data)
  );

  assign lane_idx = LANE_BITS'(lowest_set(NUM_THREADS'(out_tmask)));

  if (NB == 1) begin : g_pass
    assign out_tid = tid_q;
  end else begin : g_split
    assign out_tid = NT_WIDTH'(cur * NUM_LANES + lane_idx);
  end

  assign out_uuid    = uuid_q;
  assign out_wid     = wid_q;
  assign out_pc      = pc_q;
  assign out_op_type = op_type_q;
  assign out_op_args = op_args_q;
  assign out_rd      = rd_q;
  assign out_wb      = wb_q;
  assign out_pid     = cur;
  assign out_sop     = out_valid & sop_q;
  assign out_eop     = last_batch;

endmodule

// File: doc/alu_lane_sequencer.md
# alu_lane_sequencer

Upstream feeder for the integer ALU block. It accepts one full-warp ALU request, `NUM_THREADS` lanes wide, and splits it into `NUM_THREADS/NUM_LANES` lane batches of `NUM_LANES` lanes each. Batches whose thread mask is empty are skipped. Each emitted batch is tagged with `pid`, `sop`, `eop` and a batch-local leader `tid`, so the downstream ALU can commit partial results and resolve branches on the `eop` batch. It sits between the ALU dispatch port and the ALU block, one instance per ALU block.

## Interface
- `NUM_LANES`, default 1: lanes per output batch. Must divide `` `NUM_THREADS``.
- `BLOCK_IDX`, default 0: ALU block index. Carried for tracing only.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  warp request valid.
- `in_ready`  out  1  warp request accepted when `in_valid & in_ready`.
- `in_data`  in  execute_if data at `` `NUM_THREADS`` lanes. Fields: `uuid`, `wid`, `tmask[NUM_THREADS]`, `PC`, `op_type`, `op_args`, `rd`, `wb`, `rs1/rs2/rs3_data[NUM_THREADS][XLEN]`, `tid`.
- `out_valid`  out  1  batch valid.
- `out_ready`  in  1  batch accepted when `out_valid & out_ready`.
- `out_data`  out  execute_if data at `NUM_LANES` lanes. Fields: the scalar fields above, `tmask[NUM_LANES]`, data `[NUM_LANES][XLEN]`, `pid[PID_WIDTH]`, `sop`, `eop`, `tid[NW…` (full `NT_WIDTH` thread id).

## Operation
- `NB = NUM_THREADS/NUM_LANES`.
- **Pass-through mode, NB == 1.** The block is a single-entry elastic register.
    - `pid = 0`, `sop = eop = 1`.
    - `tid` passes through unchanged.
- **Capture.** On accept, the whole warp is latched into a holding register. A remaining-batch mask `rem[NB]` is initialised: bit b = OR of `tmask[b*NUM_LANES +: NUM_LANES]`.
- **All-zero tmask.** If `tmask` is all zero, `rem` is forced to `1` (batch 0 only), so the warp still produces exactly one `sop = eop = 1` packet.
- **Batch selection.** The current batch `cur` is the lowest set bit of `rem`, found by a priority encoder.
- **Output fields for the current batch:**
    - `pid = cur`.
    - `tmask` and data are the lane slice `cur*NUM_LANES +: NUM_LANES`.
    - `sop = 1` on the first batch emitted for the warp.
    - `eop = 1` when `rem` has exactly one bit set.
    - `tid = cur*NUM_LANES + first set bit of the batch tmask`. If the batch tmask is zero (all-zero warp case), `tid = 0`.
- **On batch accept:**
    - Clear `rem[cur]`.
    - Clear the `sop` flag.
    - On `eop`, the block returns to IDLE.
- **State machine:**
    - IDLE → BUSY on input accept.
    - BUSY → BUSY on a non-eop batch accept.
    - BUSY → IDLE on an eop accept with no new input.
    - BUSY → BUSY (new warp) on an eop accept with a simultaneous input accept.
- **Ready and valid:**
    - `in_ready = (state == IDLE) | (out_valid & out_ready & eop)`.
    - `out_valid = (state == BUSY)`.

## Timing
- **Reset.** `reset` low forces the following immediately (asynchronously), regardless of `clk`:
    - state IDLE, `rem = 0`, `sop` flag 1.
    - `out_valid = 0`.
    - All `out_data` fields 0.
    - `in_ready = 1`.
- **Reset mid-warp.** Remaining batches are discarded and nothing is replayed.
- **Latency.** A warp accepted at edge N presents its first batch from cycle N+1.
- **Throughput.** One batch per cycle while `out_ready = 1`. A warp with k non-empty batches occupies k cycles.
- **Back-to-back warps.** The next warp is accepted in the same cycle as the previous warp's eop accept, with no bubble.
- **Backpressure.** While `out_valid & ~out_ready`:
    - all `out_data` fields are held stable;
    - `rem` is unchanged;
    - `in_ready = 0` (BUSY).
- **Combinational paths.**
    - `out_data` has no combinational path from `in_data`.
    - `in_ready` depends combinationally on `out_ready`. This is the only input-to-output combinational path.

## Structure
- **Shared package** (`VX_gpu_pkg`) holds:
    - `NB`, `PID_BITS`, `PID_WIDTH`, `LANE_BITS`.
    - The sequencer state enum (`SEQ_IDLE`, `SEQ_BUSY`).
    - Fields are reused from the existing `execute_t` struct; no new struct is introduced.
- **Sub-modules.**
    - The existing `VX_priority_encoder` is instantiated twice: once over `rem`, once over the batch tmask.
    - One new sub-module, `alu_lane_slice`, is natural: the combinational mux that extracts batch `cur` from the holding register.

## Test plan
Configuration: `NUM_THREADS = 8`, `NUM_LANES = 2` (NB = 4), `out_ready = 1` unless stated.
- **Full mask.** `tmask = 0xFF`, `tid = 3` → four consecutive batches with `pid = 0,1,2,3`.
    - `sop` only on pid 0, `eop` only on pid 3.
    - `tid = 0,2,4,6`.
    - `in_ready` low for cycles 1–3 and high in the eop cycle.
- **Single batch.** `tmask = 0x30` → one batch: `pid = 2`, `tmask = 2'b11`, `sop = eop = 1`, `tid = 4`, first cycle after accept.
- **Sparse mask.** `tmask = 0x81` → pid 0 (`sop`, `tmask = 01`, `tid = 0`), then pid 3 (`eop`, `tmask = 10`, `tid = 7`). Batches 1 and 2 are never emitted.
- **Backpressure.** `tmask = 0xFF`, `out_ready` low for 3 cycles after pid 1 appears.
    - pid 1 data stays stable all 3 cycles.
    - `in_ready = 0` throughout.
    - pid 2 follows the cycle after `out_ready` rises.
- **Back-to-back and all-zero.**
    - Warp A (`tmask = 0x0C`) is followed by warp B (`tmask = 0x00`) held valid. B is accepted in A's eop cycle.
    - B yields one batch: `pid = 0`, `tmask = 00`, `sop = eop = 1`, `tid = 0`. No idle cycle between A and B.
- **Reset mid-warp.** Assert `reset` low during pid 1 of a `0xFF` warp.
    - `out_valid` drops without waiting for a clock edge.
    - After release, `in_ready = 1` and `out_valid = 0` until a new warp arrives. No residual batches appear.
